cpu_trace_capture: RTL

CPU_TRACE_CAPTURE -- requirements
Module: cpu_trace_capture

---
 rtl/cpu_trace_capture.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cpu_trace_capture.sv
// CPU instruction trace capture: stamps decode-cycle snapshots with a cycle count,
// queues them in a FIFO and streams each record out as 12 bytes over valid/ready.
module cpu_trace_capture #(
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clock_en,
    input  logic                     enable,
    input  logic                     decode,
    input  logic [15:0]              pc,
    input  logic [7:0]               opcode,
    input  logic [7:0]               a,
    input  logic [7:0]               x,
    input  logic [7:0]               y,
    input  logic [7:0]               p,
    input  logic [7:0]               sp,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output logic                     dbg_state
);
    localparam int AW = $clog2(DEPTH);

    // Output handshake: a byte moves on a rising edge where out_valid & out_ready;
    // out_data/out_last stay stable while out_valid is high and out_ready is low.
    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_idx, w_idx_nxt;
    logic [31:0]   r_cyc;
    logic [95:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count, w_count_nxt;
    logic          r_overflow;
    logic [7:0]    r_drop_cnt;

    logic          w_capture, w_full, w_push, w_drop, w_xfer, w_pop;
    logic [95:0]   w_head, w_shifted;

    assign w_capture = clock_en & enable & decode;
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    // A full FIFO drops even if the head pops on the same edge.
    assign w_push    = w_capture & ~w_full;
    assign w_drop    = w_capture & w_full;
    assign w_xfer    = (r_state == S_SEND) & out_ready;
    assign w_pop     = w_xfer & (r_idx == 4'd11);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop)
            w_count_nxt = r_count + (AW+1)'(1);
        else if (!w_push && w_pop)
            w_count_nxt = r_count - (AW+1)'(1);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = S_SEND;
                    w_idx_nxt   = 4'd0;
                end
            end
            S_SEND: begin
                if (w_xfer) begin
                    if (r_idx == 4'd11) begin
                        w_idx_nxt = 4'd0;
                        if (w_count_nxt == '0)
                            w_state_nxt = S_IDLE;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= 4'd0;
            r_cyc      <= 32'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_count <= w_count_nxt;
            if (clock_en)
                r_cyc <= r_cyc + 32'd1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF)
                    r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {pc, opcode, a, x, y, p, sp, r_cyc};
    end

    // Byte 0 is the most significant byte of the packed record.
    assign w_head    = r_mem[r_rd_ptr];
    assign w_shifted = w_head << {r_idx, 3'b000};

    assign out_valid = (r_state == S_SEND);
    assign out_data  = (r_state == S_SEND) ? w_shifted[95:88] : 8'h00;
    assign out_last  = (r_state == S_SEND) && (r_idx == 4'd11);
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;
    assign dbg_state = r_state;

endmodule
